// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Program loader for the byte-addressed instruction memory. A length-prefixed
// byte stream (16-bit big-endian length, then the data bytes) arrives over a
// valid/ready handshake. Each data byte is written in arrival order, so stream
// byte N lands at byte address N and each 4-byte word is stored most
// significant byte first. The CPU is held while a load is in progress.
//
// Optional feature macro: LOADER_CSUM_EN
//   When defined, one trailing checksum byte (XOR of all data bytes) follows
//   the data and is checked before the load is reported done.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-low reset
//   start       begin a load when idle; ignored otherwise
//   rx_valid    stream byte valid
//   rx_data     stream byte
//   rx_ready    loader accepts a byte this cycle (decoded from state)
//   mem_we      registered byte write strobe to instruction memory
//   mem_addr    registered byte write address
//   mem_wdata   registered byte write data
//   busy        load in progress
//   cpu_hold    keep the CPU stalled; same as busy
//   done        one-cycle pulse on successful completion
//   error       sticky failure flag, cleared by the next accepted start
//   byte_count  data bytes written in the current/last load
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; rx_ready low
// S_HDR_HI | accepting length high byte
// S_HDR_LO | accepting length low byte, length is validated here
// S_DATA   | accepting data bytes, one memory write per byte
// S_CSUM   | accepting checksum byte (LOADER_CSUM_EN builds only)
// S_DONE   | one-cycle success pulse, then back to idle
// S_ERR    | one-cycle failure state, error is set, then back to idle

module inst_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`ifdef LOADER_CSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  state_t state, state_nxt;

  logic [7:0]      len_hi;
  logic [ADDR_W:0] len;
  logic [15:0]     hdr_len;
  logic            len_bad;
  logic [ADDR_W:0] byte_count_inc;
  logic            last_data;

  logic ld_start;
  logic ld_hi;
  logic ld_len;
  logic wr_data;
  logic set_err;

`ifdef LOADER_CSUM_EN
  logic [7:0] csum;
`endif

  // Full header length as seen while the low byte is on the bus.
  assign hdr_len        = {len_hi, rx_data};
  assign len_bad        = (hdr_len > 16'(MAX_BYTES)) || (hdr_len[1:0] != 2'b00);
  assign byte_count_inc = byte_count + 1'b1;
  // byte_count counts bytes already written, so the byte being accepted now
  // is the last one when one more write reaches the programmed length.
  assign last_data      = (byte_count_inc == len);

  assign busy     = (state != S_IDLE);
  assign cpu_hold = busy;
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    ld_start  = 1'b0;
    ld_hi     = 1'b0;
    ld_len    = 1'b0;
    wr_data   = 1'b0;
    set_err   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          ld_start  = 1'b1;
          state_nxt = S_HDR_HI;
        end
      end

      S_HDR_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          ld_hi     = 1'b1;
          state_nxt = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_len == 16'd0) begin
            // Empty program: nothing to write and no checksum byte follows.
            state_nxt = S_DONE;
          end else if (len_bad) begin
            set_err   = 1'b1;
            state_nxt = S_ERR;
          end else begin
            ld_len    = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          wr_data = 1'b1;
          if (last_data) begin
`ifdef LOADER_CSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          end
        end
      end

`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == csum) begin
            state_nxt = S_DONE;
          end else begin
            set_err   = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
`endif

      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. The memory write port is registered, so each strobe appears the
  // cycle after its handshake and carries the pre-increment byte_count as the
  // address; byte_count itself advances on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      error      <= 1'b0;
      byte_count <= '0;
      len_hi     <= '0;
      len        <= '0;
    end else begin
      mem_we <= wr_data;

      if (ld_start) begin
        error      <= 1'b0;
        byte_count <= '0;
        len_hi     <= '0;
        len        <= '0;
      end

      if (ld_hi) begin
        len_hi <= rx_data;
      end

      if (ld_len) begin
        // len_bad has already bounded the value, so the truncation is exact.
        len <= hdr_len[ADDR_W:0];
      end

      if (wr_data) begin
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= rx_data;
        byte_count <= byte_count_inc;
      end

      if (set_err) begin
        error <= 1'b1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (ld_start) begin
      csum <= '0;
    end else if (wr_data) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] byte_count;

  int total;
  int bad;
  int done_cnt;
  logic [9:0] wa[$];
  logic [7:0] wd[$];

  inst_mem_loader #(.ADDR_W(10), .MAX_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error), .byte_count(byte_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and return at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      bad++;
      $display("FAIL send_timeout: rx_ready=%0b required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    clear_log();
    #13;
    total++;
    if ({rx_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {rx_ready, mem_we, busy, cpu_hold, done, error});
    end
    total++;
    if (mem_addr !== 10'd0 || mem_wdata !== 8'd0 || byte_count !== 11'd0) begin
      bad++;
      $display("FAIL reset_buses: addr=%0h wdata=%0h cnt=%0d required 0", mem_addr, mem_wdata, byte_count);
    end
    @(negedge clk);
    rst = 1'b1;
    // A byte offered in IDLE must be left pending.
    rx_valid = 1'b1; rx_data = 8'h5a;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: got %0b required 0", rx_ready);
    end
    idle_cycles(3);
    total++;
    if (busy !== 1'b0 || wa.size() != 0) begin
      bad++;
      $display("FAIL idle_no_accept: busy=%0b writes=%0d required 0/0", busy, wa.size());
    end
  endtask

  task automatic test_load8();
    logic [7:0] dat[8];
    logic [7:0] x;
    dat = '{8'h00, 8'h10, 8'h03, 8'h13, 8'h00, 8'h63, 8'h03, 8'h33};
    x = 8'h00;
    foreach (dat[i]) x ^= dat[i];
    clear_log();
    do_start();
    total++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL load8_busy: busy=%0b hold=%0b ready=%0b required 111", busy, cpu_hold, rx_ready);
    end
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(dat[0]);
    total++;
    if (byte_count !== 11'd1) begin
      bad++;
      $display("FAIL load8_cnt1: got %0d required 1", byte_count);
    end
    for (int i = 1; i < 8; i++) send_byte(dat[i]);
`ifdef LOADER_CSUM_EN
    send_byte(x);
`endif
    rx_valid = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load8_done: done=%0b busy=%0b required 1/1", done, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL load8_idle: busy=%0b hold=%0b done=%0b err=%0b required 0000", busy, cpu_hold, done, error);
    end
    total++;
    if (byte_count !== 11'd8 || wa.size() != 8 || done_cnt != 1) begin
      bad++;
      $display("FAIL load8_counts: cnt=%0d writes=%0d dones=%0d required 8/8/1", byte_count, wa.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== 10'(i) || wd[i] !== dat[i]) begin
        bad++;
        $display("FAIL load8_write%0d: addr=%0h data=%0h required %0h/%0h", i, wa[i], wd[i], i, dat[i]);
      end
    end
  endtask

  task automatic test_bad_len();
    clear_log();
    do_start();
    send_byte(8'h00);
    send_byte(8'h06);
    rx_valid = 1'b0;
    total++;
    if (error !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL len6_err: err=%0b busy=%0b done=%0b required 1/1/0", error, busy, done);
    end
    idle_cycles(2);
    total++;
    if (error !== 1'b1 || busy !== 1'b0 || wa.size() != 0) begin
      bad++;
      $display("FAIL len6_sticky: err=%0b busy=%0b writes=%0d required 1/0/0", error, busy, wa.size());
    end
    do_start();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL start_clears_err: got %0b required 0", error);
    end
    // Header 1028 exceeds the memory.
    send_byte(8'h04);
    send_byte(8'h04);
    idle_cycles(2);
    total++;
    if (error !== 1'b1 || wa.size() != 0 || done_cnt != 0) begin
      bad++;
      $display("FAIL len1028_err: err=%0b writes=%0d dones=%0d required 1/0/0", error, wa.size(), done_cnt);
    end
    // Zero-length program completes immediately.
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL len0_done: got %0b required 1", done);
    end
    idle_cycles(2);
    total++;
    if (byte_count !== 11'd0 || wa.size() != 0 || done_cnt != 1 || error !== 1'b0) begin
      bad++;
      $display("FAIL len0_state: cnt=%0d writes=%0d dones=%0d err=%0b required 0/0/1/0",
               byte_count, wa.size(), done_cnt, error);
    end
  endtask

  task automatic test_toggle_valid();
    logic [7:0] dat[12];
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin
      dat[i] = 8'(i * 17 + 5);
      x ^= dat[i];
    end
    clear_log();
    do_start();
    send_byte(8'h00);
    send_byte(8'h0c);
    for (int i = 0; i < 12; i++) begin
      send_byte(dat[i]);
      rx_valid = 1'b0;
      if (i == 5) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
`ifdef LOADER_CSUM_EN
    send_byte(x);
`endif
    idle_cycles(3);
    total++;
    if (wa.size() != 12 || done_cnt != 1 || byte_count !== 11'd12 || error !== 1'b0) begin
      bad++;
      $display("FAIL toggle_counts: writes=%0d dones=%0d cnt=%0d err=%0b required 12/1/12/0",
               wa.size(), done_cnt, byte_count, error);
    end
    for (int i = 0; i < 12 && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== 10'(i) || wd[i] !== dat[i]) begin
        bad++;
        $display("FAIL toggle_write%0d: addr=%0h data=%0h required %0h/%0h", i, wa[i], wd[i], i, dat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] x;
    clear_log();
    do_start();
    send_byte(8'h00);
    send_byte(8'h10);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    // Keep bytes flowing while reset hits.
    rx_data = 8'hEE;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({rx_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 8'd0 || byte_count !== 11'd0) begin
      bad++;
      $display("FAIL midrst_outputs: flags=%b addr=%0h wdata=%0h cnt=%0d required all 0",
               {rx_ready, mem_we, busy, cpu_hold, done, error}, mem_addr, mem_wdata, byte_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(3);
    total++;
    if (wa.size() != 5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_writes: writes=%0d busy=%0b required 5/0", wa.size(), busy);
    end
    clear_log();
    do_start();
    send_byte(8'h00);
    send_byte(8'h04);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'hC0 + i));
      x ^= 8'(8'hC0 + i);
    end
`ifdef LOADER_CSUM_EN
    send_byte(x);
`endif
    idle_cycles(2);
    total++;
    if (wa.size() != 4 || done_cnt != 1 || byte_count !== 11'd4) begin
      bad++;
      $display("FAIL postrst_load: writes=%0d dones=%0d cnt=%0d required 4/1/4", wa.size(), done_cnt, byte_count);
    end
    total++;
    if (wa.size() == 4 && (wa[3] !== 10'd3 || wd[3] !== 8'hC3)) begin
      bad++;
      $display("FAIL postrst_last: addr=%0h data=%0h required 3/c3", wa[3], wd[3]);
    end
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_bad_csum();
    logic [7:0] x;
    x = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    clear_log();
    do_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(~x);
    idle_cycles(2);
    total++;
    if (wa.size() != 4 || error !== 1'b1 || done_cnt != 0) begin
      bad++;
      $display("FAIL bad_csum: writes=%0d err=%0b dones=%0d required 4/1/0", wa.size(), error, done_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    test_reset();
    test_load8();
    test_bad_len();
    test_toggle_valid();
    test_reset_mid_load();
`ifdef LOADER_CSUM_EN
    test_bad_csum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
